// File: rtl/dm_ctrl.sv
// Data-memory controller: arbitrates a shared word store between a host
// (in IDLE/DONE) and a processor (in RUN), with run/access statistics.
module dm_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_start,
   output logic                  proc_start,
   input  logic                  proc_stop,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic                  dm_rd,
   input  logic                  dm_wr,
   input  logic [DATA_WIDTH-1:0] dm_w_data,
   output logic [DATA_WIDTH-1:0] dm_r_data,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  run_cycles,
   output logic [CNT_WIDTH-1:0]  rd_cnt,
   output logic [CNT_WIDTH-1:0]  wr_cnt,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;

   logic                  pstart_q, pstart_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] hrdat_q, hrdat_d;
   logic [CNT_WIDTH-1:0]  runc_q, runc_d;
   logic [CNT_WIDTH-1:0]  rdc_q, rdc_d;
   logic [CNT_WIDTH-1:0]  wrc_q, wrc_d;
   logic                  err_q, err_d;

   logic                  run;
   logic                  p_rd, p_wr, p_err;
   logic                  h_acc;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_comb begin
      state_d  = state_q;
      run      = (state_q == RUN);
      p_wr     = run & dm_wr;
      p_rd     = run & dm_rd & ~dm_wr;
      p_err    = (dm_rd | dm_wr) & (~run | (dm_rd & dm_wr));
      // One accept per two cycles: no accept while the previous ack is out.
      h_acc    = host_req & ~run & ~ack_q;
      mem_we   = rst & (p_wr | (h_acc & host_we));
      mem_wa   = p_wr ? dm_addr : host_addr;
      mem_wd   = p_wr ? dm_w_data : host_wdata;
      rdat_d   = rdat_q;
      hrdat_d  = hrdat_q;
      runc_d   = runc_q;
      rdc_d    = rdc_q;
      wrc_d    = wrc_q;
      err_d    = err_q | p_err;
      ack_d    = h_acc;

      unique case (state_q)
         IDLE:    if (host_start) state_d = RUN;
         RUN:     if (proc_stop)  state_d = DONE;
         DONE:    if (host_start) state_d = RUN;
         default: state_d = IDLE;
      endcase

      pstart_d = (state_q != RUN) && (state_d == RUN);

      if (p_rd)
         rdat_d = mem_q[dm_addr];
      if (h_acc && !host_we)
         hrdat_d = mem_q[host_addr];
      if (run && !(&runc_q))
         runc_d = runc_q + CNT_WIDTH'(1);
      if (p_rd && !(&rdc_q))
         rdc_d = rdc_q + CNT_WIDTH'(1);
      if (p_wr && !(&wrc_q))
         wrc_d = wrc_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         pstart_q <= 1'b0;
         rdat_q   <= '0;
         ack_q    <= 1'b0;
         hrdat_q  <= '0;
         runc_q   <= '0;
         rdc_q    <= '0;
         wrc_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pstart_q <= pstart_d;
         rdat_q   <= rdat_d;
         ack_q    <= ack_d;
         hrdat_q  <= hrdat_d;
         runc_q   <= runc_d;
         rdc_q    <= rdc_d;
         wrc_q    <= wrc_d;
         err_q    <= err_d;
      end
   end

   // Storage survives reset; only writes are gated while reset is held.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[mem_wa] <= mem_wd;
   end

   assign proc_start = pstart_q;
   assign dm_r_data  = rdat_q;
   assign host_ack   = ack_q;
   assign host_rdata = hrdat_q;
   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign run_cycles = runc_q;
   assign rd_cnt     = rdc_q;
   assign wr_cnt     = wrc_q;
   assign err        = err_q;

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 8, data-memory address width; DATA_WIDTH, 16, word width; CNT_WIDTH, 16, counter width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-low reset
- host_start  in  1  host request to run the processor
- proc_start  out  1  start pulse to processor
- proc_stop  in  1  processor stop indication
- dm_addr  in  ADDR_WIDTH  processor data address
- dm_rd  in  1  processor read enable
- dm_wr  in  1  processor write enable
- dm_w_data  in  DATA_WIDTH  processor write data
- dm_r_data  out  DATA_WIDTH  registered read data to processor
- host_req  in  1  host access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_ack  out  1  host access done
- host_rdata  out  DATA_WIDTH  host read data, valid with host_ack
- busy  out  1  high in RUN
- done  out  1  high in DONE
- run_cycles  out  CNT_WIDTH  cycles spent in RUN
- rd_cnt  out  CNT_WIDTH  processor reads served
- wr_cnt  out  CNT_WIDTH  processor writes served
- err  out  1  sticky protocol error

Function
REQ-004 Storage SHALL be 2^ADDR_WIDTH x DATA_WIDTH words, synchronous write, registered read.
REQ-005 FSM states SHALL be IDLE, RUN, DONE.
- IDLE -> RUN on host_start=1.
- RUN -> DONE on proc_stop=1.
- DONE -> RUN on host_start=1.
- All other cases: hold state.
REQ-006 proc_start SHALL be a one-cycle pulse in the cycle after each IDLE/DONE -> RUN transition.
REQ-007 Processor accesses SHALL be served only in RUN.
REQ-008 Processor read: dm_rd=1, dm_wr=0 in cycle N SHALL present mem[dm_addr] on dm_r_data in cycle N+1; rd_cnt SHALL increment.
REQ-009 dm_r_data SHALL hold its last value when no read is served.
REQ-010 Processor write: dm_wr=1 in cycle N SHALL update mem[dm_addr] at the end of cycle N; wr_cnt SHALL increment.
REQ-011 A read of an address written in the previous cycle SHALL return the new data.
REQ-012 dm_rd=1 and dm_wr=1 together SHALL perform the write only, leave dm_r_data unchanged, not count a read, and set err.
REQ-013 dm_rd or dm_wr asserted outside RUN SHALL be ignored (no memory change, no count) and SHALL set err.
REQ-014 Host accesses SHALL be served only in IDLE or DONE.
- host_req in cycle N produces host_ack=1 in cycle N+1 for one cycle.
- Read data appears on host_rdata in the same cycle as host_ack.
- Host write commits at the end of cycle N.
- host_req held high SHALL be served once per two cycles: a req is not accepted in the cycle its ack is high.
REQ-015 host_req in RUN SHALL be stalled: no ack. A request still held when RUN exits SHALL be served from the first IDLE/DONE cycle.
REQ-016 A host request accepted in the same cycle host_start causes the RUN transition SHALL still complete and ack.
REQ-017 run_cycles SHALL increment every RUN cycle and not reset on DONE -> RUN.
REQ-018 run_cycles, rd_cnt and wr_cnt SHALL saturate at all-ones.
REQ-019 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both registered-state decodes.

Reset
REQ-020 When rst=0 at a clock edge, the block SHALL enter IDLE and clear proc_start, dm_r_data, host_ack, host_rdata, run_cycles, rd_cnt, wr_cnt and err; busy and done SHALL be 0.
REQ-021 Reset SHALL NOT clear memory contents. Reset mid-RUN SHALL abort the run and drop any pending host ack.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Host loads: in IDLE, host write 0x1234 at addr 0x05, then host read 0x05 -> host_ack one cycle after each req, host_rdata=0x1234.
- Run: host_start -> proc_start pulse next cycle, busy=1. Processor write 0xBEEF at 0x10 in cycle N, read 0x10 in N+1 -> dm_r_data=0xBEEF in N+2, wr_cnt=1, rd_cnt=1.
- Stop: proc_stop after 20 RUN cycles -> done=1, run_cycles=20. host_req raised during RUN acks only after DONE entry.
- Errors: dm_rd=dm_wr=1 at 0x20 with data 0x0007 -> mem[0x20]=0x0007, rd_cnt unchanged, err=1. dm_wr in IDLE -> memory unchanged, err=1.
- Saturation: force 2^CNT_WIDTH+3 RUN cycles -> run_cycles=0xFFFF.
- Reset: rst=0 mid-RUN -> IDLE, counters 0, err 0. A prior host read of 0x05 still returns 0x1234.
